// File: rtl/servo_pkg.sv
// Shared types, widths and helpers for the servo command front-end and frame timer.
package servo_pkg;

   localparam int VALUE_W          = 10;
   localparam int STEP_W           = 6;
   localparam int FRAME_CW         = 19;
   localparam int FRAME_CYCLES_DEF = 333500;
   localparam int VMIN_DEF         = 32;
   localparam int VMAX_DEF         = 1000;
   localparam int WDOG_FRAMES_DEF  = 50;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      RAMP     = 2'd1,
      HOLD     = 2'd2
   } servo_state_t;

   typedef struct packed {
      servo_state_t          state;
      logic [FRAME_CW-1:0]   frame_cnt;
   } servo_dbg_t;

   // Zero is the disarm code and passes through unclamped.
   function automatic logic [VALUE_W-1:0] clamp_target(input logic [VALUE_W-1:0] t,
                                                       input logic [VALUE_W-1:0] lo,
                                                       input logic [VALUE_W-1:0] hi);
      if (t == '0) return '0;
      if (t < lo) return lo;
      if (t > hi) return hi;
      return t;
   endfunction

   // One frame of slew: 11-bit sum/difference so neither direction can wrap.
   function automatic logic [VALUE_W-1:0] next_value(input logic [VALUE_W-1:0] v,
                                                     input logic [VALUE_W-1:0] t,
                                                     input logic [STEP_W-1:0]  s);
      logic [VALUE_W:0] sum;
      logic [VALUE_W:0] diff;
      sum  = {1'b0, v} + {{(VALUE_W - STEP_W + 1){1'b0}}, s};
      diff = {1'b0, v} - {{(VALUE_W - STEP_W + 1){1'b0}}, s};
      if (t == '0) return '0;
      if (v == '0 || s == '0) return t;
      if (v < t) return (sum > {1'b0, t}) ? t : sum[VALUE_W-1:0];
      if (v > t) return (diff[VALUE_W] || diff[VALUE_W-1:0] < t) ? t : diff[VALUE_W-1:0];
      return v;
   endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter with a last-cycle tick; shared with the PWM generator
// so both stages agree on frame boundaries.
import servo_pkg::*;

module servo_frame_timer #(
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                rst,
   output logic [FRAME_CW-1:0] frame_cnt,
   output logic                frame_tick
);

   localparam logic [FRAME_CW-1:0] LAST = FRAME_CW'(FRAME_CYCLES - 1);

   logic [FRAME_CW-1:0] cnt_q;
   logic [FRAME_CW-1:0] cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + FRAME_CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign frame_cnt  = cnt_q;
   assign frame_tick = (cnt_q == LAST);

endmodule

// File: rtl/servo_ramp.sv
// Frame-aligned, slew-limited position command front-end for the servo PWM stage.
// Optional command watchdog is compiled in with SERVO_RAMP_WDOG_EN.
import servo_pkg::*;

module servo_ramp #(
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
   parameter int VMIN         = VMIN_DEF,
   parameter int VMAX         = VMAX_DEF,
   parameter int WDOG_FRAMES  = WDOG_FRAMES_DEF
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               CMD_VALID,
   output logic               CMD_READY,
   input  logic [VALUE_W-1:0] CMD_TARGET,
   input  logic [STEP_W-1:0]  CMD_STEP,
   output logic [VALUE_W-1:0] VALUE,
   output logic               FRAME_TICK,
   output logic               BUSY,
   output logic               WDOG_TRIP,
   output servo_dbg_t         DBG
);

   localparam logic [VALUE_W-1:0] VMIN_V = VALUE_W'(VMIN);
   localparam logic [VALUE_W-1:0] VMAX_V = VALUE_W'(VMAX);

   // Handshake: a command transfers in any cycle where CMD_VALID and CMD_READY are
   // both high; CMD_READY is high exactly when the one-deep slot is empty, and a
   // producer seeing CMD_READY low must hold CMD_VALID and its payload stable.

   logic [FRAME_CW-1:0] frame_cnt;
   logic                frame_tick;
   logic                accept;
   logic                wdog_trip;

   logic [VALUE_W-1:0] value_q,       value_d;
   logic [VALUE_W-1:0] target_q,      target_d;
   logic [STEP_W-1:0]  step_q,        step_d;
   logic               slot_full_q,   slot_full_d;
   logic [VALUE_W-1:0] slot_target_q, slot_target_d;
   logic [STEP_W-1:0]  slot_step_q,   slot_step_d;
   servo_state_t       state_q,       state_d;

   servo_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
      .clk        (CLK),
      .rst        (RST),
      .frame_cnt  (frame_cnt),
      .frame_tick (frame_tick)
   );

   assign accept = CMD_VALID && !slot_full_q;

`ifdef SERVO_RAMP_WDOG_EN
   localparam int                WDOG_W  = $clog2(WDOG_FRAMES + 1);
   localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_FRAMES);
   localparam logic [WDOG_W-1:0] WDOG_PRE = WDOG_W'(WDOG_FRAMES - 1);

   logic [WDOG_W-1:0] wdog_q, wdog_d;

   // Counter saturates at the limit so a disarmed, idle servo trips only once.
   always_comb begin
      wdog_d = wdog_q;
      if (accept)                              wdog_d = '0;
      else if (frame_tick && wdog_q != WDOG_LIM) wdog_d = wdog_q + WDOG_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) wdog_q <= '0;
      else     wdog_q <= wdog_d;
   end

   assign wdog_trip = frame_tick && !accept && (wdog_q == WDOG_PRE);
`else
   assign wdog_trip = 1'b0;
`endif

   always_comb begin
      value_d       = value_q;
      target_d      = target_q;
      step_d        = step_q;
      slot_full_d   = slot_full_q;
      slot_target_d = slot_target_q;
      slot_step_d   = slot_step_q;

      if (frame_tick && slot_full_q) begin
         target_d    = clamp_target(slot_target_q, VMIN_V, VMAX_V);
         step_d      = slot_step_q;
         slot_full_d = 1'b0;
      end
      // Only possible with the slot empty, so it never collides with the transfer.
      if (accept) begin
         slot_full_d   = 1'b1;
         slot_target_d = CMD_TARGET;
         slot_step_d   = CMD_STEP;
      end
      if (frame_tick) value_d = next_value(value_q, target_d, step_d);

      if (wdog_trip) begin
         target_d    = '0;
         slot_full_d = 1'b0;
         value_d     = '0;
      end

      if (value_d == '0)            state_d = DISARMED;
      else if (value_d == target_d) state_d = HOLD;
      else                          state_d = RAMP;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         value_q       <= '0;
         target_q      <= '0;
         step_q        <= '0;
         slot_full_q   <= 1'b0;
         slot_target_q <= '0;
         slot_step_q   <= '0;
         state_q       <= DISARMED;
      end else begin
         value_q       <= value_d;
         target_q      <= target_d;
         step_q        <= step_d;
         slot_full_q   <= slot_full_d;
         slot_target_q <= slot_target_d;
         slot_step_q   <= slot_step_d;
         state_q       <= state_d;
      end
   end

   assign CMD_READY     = !slot_full_q;
   assign VALUE         = value_q;
   assign FRAME_TICK    = frame_tick;
   assign BUSY          = (value_q != target_q);
   assign WDOG_TRIP     = wdog_trip;
   assign DBG.state     = state_q;
   assign DBG.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_servo_ramp.sv
// Self-checking bench for servo_ramp: directed scenarios plus randomized traffic
// against a frame-level reference model (honours SERVO_RAMP_WDOG_EN).
import servo_pkg::*;

module tb_servo_ramp;

   localparam int FC = 10;
   localparam int VMN = 32;
   localparam int VMX = 1000;
   localparam int WF = 4;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [9:0] cmd_target = '0;
   logic [5:0] cmd_step = '0;
   logic [9:0] value;
   logic       frame_tick;
   logic       busy;
   logic       wdog_trip;
   servo_dbg_t dbg;

   always #5 clk = ~clk;

   servo_ramp #(.FRAME_CYCLES(FC), .VMIN(VMN), .VMAX(VMX), .WDOG_FRAMES(WF)) dut (
      .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
      .CMD_TARGET(cmd_target), .CMD_STEP(cmd_step), .VALUE(value),
      .FRAME_TICK(frame_tick), .BUSY(busy), .WDOG_TRIP(wdog_trip), .DBG(dbg)
   );

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- reference model ----------------
   typedef struct { int target; int step; } cmd_t;
   cmd_t slot_q[$];
   int m_cnt, m_val, m_tgt, m_step, m_wdog;
   bit m_acc;
   bit e_tick, e_ready, e_busy, e_trip;
   bit s_tick, s_ready, s_busy, s_trip, s_prev_tick;
   int trip_pulses = 0;

   function automatic int m_clamp(int t);
      if (t == 0) return 0;
      if (t < VMN) return VMN;
      if (t > VMX) return VMX;
      return t;
   endfunction

   function automatic int m_next(int v, int t, int s);
      if (t == 0) return 0;
      if (v == 0 || s == 0) return t;
      if (v < t) return (v + s < t) ? v + s : t;
      if (v > t) return (v - s > t) ? v - s : t;
      return v;
   endfunction

   function automatic servo_state_t m_state();
      if (m_val == 0) return DISARMED;
      if (m_val == m_tgt) return HOLD;
      return RAMP;
   endfunction

   task automatic model_step();
      bit tick, acc, trip;
      cmd_t c;
      tick = (m_cnt == FC - 1);
      acc  = cmd_valid && (slot_q.size() == 0);
      trip = 1'b0;
`ifdef SERVO_RAMP_WDOG_EN
      trip = tick && !acc && (m_wdog + 1 == WF);
`endif
      e_tick = tick; e_ready = (slot_q.size() == 0); e_busy = (m_val != m_tgt); e_trip = trip;
      m_acc = 1'b0;
      if (rst) begin
         slot_q.delete();
         m_cnt = 0; m_val = 0; m_tgt = 0; m_step = 0; m_wdog = 0;
         return;
      end
      m_acc = acc;
      if (tick && slot_q.size() != 0) begin
         c = slot_q.pop_front();
         m_tgt = m_clamp(c.target);
         m_step = c.step;
      end
      if (acc) slot_q.push_back('{int'(cmd_target), int'(cmd_step)});
      if (tick) m_val = m_next(m_val, m_tgt, m_step);
`ifdef SERVO_RAMP_WDOG_EN
      if (acc) m_wdog = 0;
      else if (tick && m_wdog < WF) m_wdog++;
      if (trip) begin m_tgt = 0; slot_q.delete(); m_val = 0; end
`endif
      m_cnt = (m_cnt + 1) % FC;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(negedge clk);
      s_prev_tick = s_tick;
      s_tick = frame_tick; s_ready = cmd_ready; s_busy = busy; s_trip = wdog_trip;
      trip_pulses += int'(wdog_trip);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input int t, input int s);
      int n;
      n = 0;
      cmd_valid = 1'b1; cmd_target = 10'(t); cmd_step = 6'(s);
      do begin cycle(); n++; end while (!m_acc && n < 50);
      cmd_valid = 1'b0;
      n_checks++;
      if (!m_acc) begin n_errors++; $display("FAIL send_cmd_timeout target=%0d waited=%0d cycles", t, n); end
   endtask

   task automatic run_to_tick();
      int n;
      n = 0;
      do begin cycle(); n++; end while (!e_tick && n < 30);
      n_checks++;
      if (!e_tick) begin n_errors++; $display("FAIL tick_timeout waited=%0d cycles", n); end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int ticks;
      rst = 1'b1; cycle(); cycle(); rst = 1'b0;
      n_checks++; if (value !== 10'd0) begin n_errors++; $display("FAIL reset_value got=%0d exp=0", value); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if (wdog_trip !== 1'b0) begin n_errors++; $display("FAIL reset_trip got=%b exp=0", wdog_trip); end
      n_checks++; if (dbg.state !== DISARMED) begin n_errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg.state, DISARMED); end
      n_checks++; if (dbg.frame_cnt !== 19'd0) begin n_errors++; $display("FAIL reset_frame_cnt got=%0d exp=0", dbg.frame_cnt); end
      ticks = 0;
      for (int k = 0; k < 30; k++) begin
         cycle();
         ticks += int'(s_tick);
         n_checks++;
         if (s_tick !== (k % 10 == 9)) begin n_errors++; $display("FAIL idle_tick cycle=%0d got=%b exp=%b", k, s_tick, (k % 10 == 9)); end
         n_checks++;
         if (value !== 10'd0 || s_ready !== 1'b1 || s_busy !== 1'b0) begin
            n_errors++; $display("FAIL idle_outputs cycle=%0d value=%0d ready=%b busy=%b exp 0/1/0", k, value, s_ready, s_busy);
         end
      end
      n_checks++; if (ticks != 3) begin n_errors++; $display("FAIL idle_tick_count got=%0d exp=3", ticks); end
   endtask

   task automatic test_jump();
      cycle(); cycle(); cycle();
      send_cmd(500, 0);
      n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL jump_ready_after_accept got=%b exp=0", cmd_ready); end
      n_checks++; if (value !== 10'd0) begin n_errors++; $display("FAIL jump_value_before_tick got=%0d exp=0", value); end
      run_to_tick();
      n_checks++; if (value !== 10'd500) begin n_errors++; $display("FAIL jump_value got=%0d exp=500", value); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL jump_busy got=%b exp=0", busy); end
      n_checks++; if (dbg.state !== HOLD) begin n_errors++; $display("FAIL jump_state got=%0d exp=%0d", dbg.state, HOLD); end
   endtask

   task automatic test_ramp();
      int exp_v[4] = '{508, 516, 524, 530};
      send_cmd(530, 8);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) send_cmd(530, 8);
         run_to_tick();
         n_checks++; if (value !== 10'(exp_v[i])) begin n_errors++; $display("FAIL ramp_value step=%0d got=%0d exp=%0d", i, value, exp_v[i]); end
         n_checks++; if (busy !== (i != 3)) begin n_errors++; $display("FAIL ramp_busy step=%0d got=%b exp=%b", i, busy, (i != 3)); end
         n_checks++;
         if (dbg.state !== ((i == 3) ? HOLD : RAMP)) begin n_errors++; $display("FAIL ramp_state step=%0d got=%0d", i, dbg.state); end
      end
   endtask

   task automatic test_clamp();
      send_cmd(1020, 0);
      run_to_tick();
      n_checks++; if (value !== 10'd1000) begin n_errors++; $display("FAIL clamp_high got=%0d exp=1000", value); end
      send_cmd(5, 0);
      run_to_tick();
      n_checks++; if (value !== 10'd32) begin n_errors++; $display("FAIL clamp_low got=%0d exp=32", value); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL clamp_busy got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      send_cmd(600, 0);
      n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_ready_low got=%b exp=0", cmd_ready); end
      send_cmd(700, 0);
      n_checks++;
      if (s_prev_tick !== 1'b1 || s_ready !== 1'b1) begin
         n_errors++; $display("FAIL b2b_accept_timing prev_tick=%b ready=%b exp 1/1", s_prev_tick, s_ready);
      end
      n_checks++; if (value !== 10'd600) begin n_errors++; $display("FAIL b2b_first got=%0d exp=600", value); end
      run_to_tick();
      n_checks++; if (value !== 10'd700) begin n_errors++; $display("FAIL b2b_second got=%0d exp=700", value); end
   endtask

   task automatic test_wdog();
      send_cmd(600, 0);
      trip_pulses = 0;
      for (int i = 0; i < 3; i++) run_to_tick();
      n_checks++; if (value !== 10'd600) begin n_errors++; $display("FAIL wdog_before got=%0d exp=600", value); end
      run_to_tick();
`ifdef SERVO_RAMP_WDOG_EN
      n_checks++; if (value !== 10'd0) begin n_errors++; $display("FAIL wdog_value got=%0d exp=0", value); end
      n_checks++; if (trip_pulses != 1) begin n_errors++; $display("FAIL wdog_pulses got=%0d exp=1", trip_pulses); end
      n_checks++; if (s_trip !== 1'b1) begin n_errors++; $display("FAIL wdog_on_tick got=%b exp=1", s_trip); end
`else
      n_checks++; if (value !== 10'd600) begin n_errors++; $display("FAIL wdog_value got=%0d exp=600", value); end
      n_checks++; if (trip_pulses != 0) begin n_errors++; $display("FAIL wdog_pulses got=%0d exp=0", trip_pulses); end
`endif
   endtask

   task automatic test_reset_mid_ramp();
      send_cmd(40, 0);
      run_to_tick();
      send_cmd(1000, 1);
      run_to_tick();
      n_checks++; if (value !== 10'd41) begin n_errors++; $display("FAIL midramp_value got=%0d exp=41", value); end
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL midramp_busy got=%b exp=1", busy); end
      send_cmd(900, 0);
      cycle();
      rst = 1'b1; cycle(); rst = 1'b0;
      n_checks++; if (value !== 10'd0) begin n_errors++; $display("FAIL midramp_reset_value got=%0d exp=0", value); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL midramp_reset_ready got=%b exp=1", cmd_ready); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midramp_reset_busy got=%b exp=0", busy); end
      n_checks++; if (dbg.frame_cnt !== 19'd0) begin n_errors++; $display("FAIL midramp_reset_cnt got=%0d exp=0", dbg.frame_cnt); end
   endtask

   task automatic test_random();
      int sel;
      for (int i = 0; i < 500; i++) begin
         if (m_acc || !cmd_valid) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 7);
            if (sel == 0)      cmd_target = 10'd0;
            else if (sel == 1) cmd_target = 10'($urandom_range(1, 31));
            else if (sel == 2) cmd_target = 10'($urandom_range(1001, 1023));
            else               cmd_target = 10'($urandom_range(32, 1000));
            cmd_step = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         end
         rst = ($urandom_range(0, 199) == 0);
         cycle();
         n_checks++; if (s_tick !== e_tick) begin n_errors++; $display("FAIL rnd_tick i=%0d got=%b exp=%b", i, s_tick, e_tick); end
         n_checks++; if (s_ready !== e_ready) begin n_errors++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, s_ready, e_ready); end
         n_checks++; if (s_busy !== e_busy) begin n_errors++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, s_busy, e_busy); end
         n_checks++; if (s_trip !== e_trip) begin n_errors++; $display("FAIL rnd_trip i=%0d got=%b exp=%b", i, s_trip, e_trip); end
         n_checks++; if (value !== 10'(m_val)) begin n_errors++; $display("FAIL rnd_value i=%0d got=%0d exp=%0d", i, value, m_val); end
         n_checks++; if (dbg.state !== m_state()) begin n_errors++; $display("FAIL rnd_state i=%0d got=%0d exp=%0d", i, dbg.state, m_state()); end
         n_checks++; if (dbg.frame_cnt !== 19'(m_cnt)) begin n_errors++; $display("FAIL rnd_frame_cnt i=%0d got=%0d exp=%0d", i, dbg.frame_cnt, m_cnt); end
      end
      rst = 1'b0;
      cmd_valid = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_jump();
      test_ramp();
      test_clamp();
      test_back_to_back();
      test_wdog();
      test_reset_mid_ramp();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
